uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive stage of the UART controller. It sits between the `uart_rx_i` pad and the Wishbone register block, which reads it through address 2 (data) and address 1 (status). It synchronises the line, finds and validates start bits, samples 8N1 frames at mid-bit using the register-programmed `baud_div`, and buffers received bytes in a first-word-fall-through FIFO.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, 2 or more.

Ports:
- `clk_i`  in  1: system clock; single clock domain.
- `rst_i`  in  1: reset, synchronous, active-high.
- `baud_div_i`  in  16: clock cycles per bit; value 0 or 1 disables reception.
- `stall_i`  in  1: high means the receiver is disabled (drive as `~rx_en`).
- `re_i`  in  1: single-cycle pop of the FIFO head.
- `data_o`  out  8: FIFO head, valid while `empty_o`=0.
- `full_o`  out  1: FIFO holds `FIFO_DEPTH` bytes.
- `empty_o`  out  1: FIFO holds 0 bytes.
- `frame_err_o`  out  1: one-cycle pulse when a stop bit samples 0.
- `overrun_o`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `rx_i`  in  1: asynchronous serial line; idle level is 1.

## Operation
- **Synchroniser:** 2-FF synchroniser on `rx_i`, reset to 1. The output is `rx_s`. All decisions use `rx_s` only.
- **Bit counter:** `cnt` is 16 bits. "Wait N" means load `cnt`=N-1, decrement each cycle, and act on the cycle with `cnt`==0.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- **IDLE:** if `rx_s`=0, `stall_i`=0 and `baud_div_i`≥2, go to START and wait `baud_div_i>>1`.
- **START:** on expiry, if `rx_s`=0 go to DATA, clear `bitn`, and wait `baud_div_i`. Otherwise it was a glitch; go to IDLE.
- **DATA:** on expiry, shift `rx_s` into the shift register, LSB first. Increment `bitn`. After the 8th sample go to STOP; otherwise reload the wait with `baud_div_i`.
- **STOP:** wait `baud_div_i`, then sample `rx_s`.
  - Sample 1: push the byte and go to IDLE.
  - Sample 0: pulse `frame_err_o`, discard the byte, and go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then go to IDLE. This prevents a broken line or break condition from re-triggering endlessly.
- **Stall or disable mid-frame:** `stall_i`=1 or `baud_div_i`<2 in any non-IDLE state aborts the frame. The FSM goes to IDLE on the next edge with no push and no error pulse. FIFO contents are kept and remain readable.
- **`baud_div_i` changes mid-frame:** the new value takes effect at the next counter reload. No other protection is provided.
- **FIFO push:** a push occurs only on a good stop bit.
  - If the FIFO is full and `re_i`=0 that cycle, drop the byte and pulse `overrun_o`.
  - If the FIFO is full and `re_i`=1 the same cycle, both the pop and the push succeed and the count is unchanged.
- **FIFO pop:**
  - `re_i` while empty is ignored.
  - `re_i` and push together while empty: the push succeeds and the pop is ignored.
- **FIFO pointers:** read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo the depth. The count register is `$clog2(FIFO_DEPTH)+1` bits. `full_o` and `empty_o` are decoded from the count.
- **`data_o`:** combinational read of `mem[rd_ptr]`. `re_i` advances `rd_ptr` on the clock edge, so the next byte appears the following cycle.

## Timing
- **Reset values:**
  - Outputs: `empty_o`=1, `full_o`=0, `frame_err_o`=0, `overrun_o`=0.
  - `data_o` is don't-care while empty and must not be X-checked.
  - Internal: pointers, count and `cnt` are 0; FSM is IDLE.
- **Reset mid-frame:** the frame is lost and the FIFO is emptied.
- **Start detection:** a falling edge on `rx_i` at edge E reaches `rx_s` at E+2. The FSM enters START at E+3.
- **Sample points:**
  - Start-bit sample: E+3+(`baud_div_i>>1`).
  - Data bit k (0..7): E+3+(`baud_div_i>>1`)+(k+1)·`baud_div_i`.
  - Stop bit: E+3+(`baud_div_i>>1`)+9·`baud_div_i`.
- **Byte visible:** `empty_o` falls, and `data_o` shows the byte, one cycle after the stop sample.
- **Pulses:** `frame_err_o` and `overrun_o` assert on the cycle after the stop sample and last exactly 1 cycle.
- **Back-to-back frames:** a new start bit may begin immediately after the stop bit. IDLE is re-entered at mid-stop, so no idle gap is required.

## Structure
- **Package `uart_pkg`:** holds `rx_state_t` (the five FSM states) and `UART_FIFO_DEPTH`=8. `uart_tx` later shares the same package.
- **Sub-module `uart_fifo`:** synchronous FWFT FIFO, parameterised by width and depth, with ports `we`, `re`, `din`, `dout`, `full`, `empty`. It is reused by the TX path.
- **Top level:** the synchroniser, counter and FSM live in `uart_rx_core` itself.

## Test plan
- **Single byte:** `baud_div_i`=16; send 0xA5 as 8N1 -> `empty_o` falls at the computed cycle, `data_o`=0xA5; one `re_i` -> `empty_o`=1.
- **Glitch rejection:** a 0 pulse of 5 cycles with `baud_div_i`=16 -> no push, FSM returns to IDLE, no error pulse. Then 0x3C back-to-back with 0xC3 -> both bytes read in order.
- **Framing error:** send 0x55 with stop bit 0, then hold the line low for 40 cycles -> exactly one `frame_err_o` pulse, FIFO empty, no restart until the line returns high. The next frame 0x12 is received correctly.
- **Full and overrun:** send 9 bytes 0x01..0x09 with no reads -> `full_o`=1 after 0x08, one `overrun_o` pulse, reads return 0x01..0x08. Repeat with `re_i` asserted on the 9th byte's push cycle -> no overrun, 0x09 kept.
- **Stall and disable:** assert `stall_i` mid-data-bit 3 -> no push, FIFO intact. Set `baud_div_i`=0 with activity on the line -> FSM stays IDLE.
- **Reset mid-frame:** assert `rst_i` during DATA with 2 bytes queued -> `empty_o`=1 next cycle. The following frame 0x7E is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default FIFO depth.
// The TX path imports the same package.
package uart_pkg;

    localparam int UART_FIFO_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with a count register.
// The head is read combinationally; a pop advances it on the clock edge.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = re && !empty;
    // A full FIFO still accepts a write when a pop frees the head slot in the same cycle.
    assign do_push = we && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: line synchroniser, mid-bit sampling FSM driven by baud_div_i,
// and an FWFT byte FIFO with framing-error and overrun pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] baud_div_i,
    input  logic        stall_i,
    input  logic        re_i,
    output logic [7:0]  data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        frame_err_o,
    output logic        overrun_o,
    input  logic        rx_i
);
    rx_state_t   state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bitn_reg, bitn_next;
    logic [7:0]  shift_reg, shift_next;
    logic        rx_meta_reg, rx_s_reg;
    logic        frame_err_reg, frame_err_next;
    logic        overrun_reg;
    logic        push;
    logic        rx_enabled;
    logic        cnt_expired;
    logic [15:0] half_div;

    assign rx_enabled  = !stall_i && (baud_div_i >= 16'd2);
    assign cnt_expired = (cnt_reg == 16'd0);
    assign half_div    = baud_div_i >> 1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx_i;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bitn_reg      <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bitn_reg      <= bitn_next;
            shift_reg     <= shift_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= push && full_o && !re_i;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bitn_next      = bitn_reg;
        shift_next     = shift_reg;
        push           = 1'b0;
        frame_err_next = 1'b0;
        // Stalling or disabling the receiver silently abandons any frame in progress.
        if (state_reg != IDLE && !rx_enabled) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (!rx_s_reg && rx_enabled) begin
                        state_next = START;
                        cnt_next   = half_div - 16'd1;
                    end
                end
                START: begin
                    if (cnt_expired) begin
                        if (!rx_s_reg) begin
                            state_next = DATA;
                            bitn_next  = '0;
                            cnt_next   = baud_div_i - 16'd1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_expired) begin
                        shift_next = {rx_s_reg, shift_reg[7:1]};
                        bitn_next  = bitn_reg + 3'd1;
                        cnt_next   = baud_div_i - 16'd1;
                        if (bitn_reg == 3'd7) begin
                            state_next = STOP;
                        end
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_expired) begin
                        if (rx_s_reg) begin
                            push       = 1'b1;
                            state_next = IDLE;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = WAIT_HIGH;
                        end
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_reg) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign frame_err_o = frame_err_reg;
    assign overrun_o   = overrun_reg;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (push),
        .re    (re_i),
        .din   (shift_reg),
        .dout  (data_o),
        .full  (full_o),
        .empty (empty_o)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus queues expected bytes, a negedge
// monitor pops the FIFO and compares, and pulse counters track error outputs.
module tb_uart_rx_core;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] baud_div_i = 16'd16;
    logic        stall_i = 1'b0;
    logic        re_i = 1'b0;
    logic [7:0]  data_o;
    logic        full_o;
    logic        empty_o;
    logic        frame_err_o;
    logic        overrun_o;
    logic        rx_i = 1'b1;

    uart_rx_core #(.FIFO_DEPTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .baud_div_i  (baud_div_i),
        .stall_i     (stall_i),
        .re_i        (re_i),
        .data_o      (data_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .rx_i        (rx_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    bit         auto_read = 1'b0;
    int         force_pop_at = -1;
    int         exp_fall_cyc = -1;
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Read-side monitor: decides re_i for the next edge and scores every popped byte.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                re_i = 1'b0;
            end else begin
                if (!empty_o && exp_fall_cyc >= 0) begin
                    check("empty_fall_cycle", cyc, exp_fall_cyc);
                    exp_fall_cyc = -1;
                end
                if (!empty_o && (auto_read || cyc + 1 == force_pop_at)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(data_o), 256);
                    end else begin
                        $display("pop  cycle %0d data 0x%02h expected 0x%02h", cyc, data_o, exp_q[0]);
                        check("rx_byte", int'(data_o), int'(exp_q.pop_front()));
                    end
                    re_i = 1'b1;
                end else begin
                    re_i = 1'b0;
                end
            end
        end
    end

    // Pulse counters; a pulse held for two samples is a width failure.
    initial begin
        bit fe_prev = 1'b0;
        bit ov_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (frame_err_o) begin
                fe_cnt++;
                if (fe_prev) check("frame_err_width", 2, 1);
            end
            if (overrun_o) begin
                ov_cnt++;
                if (ov_prev) check("overrun_width", 2, 1);
            end
            fe_prev = frame_err_o;
            ov_prev = overrun_o;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // All stimulus keeps the invariant: current time is 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_len,
                              input bit exp_push, input bit force_pop, input bit time_fall,
                              input int hold_low);
        logic [9:0] frame;
        int e, s;
        frame = {stop, b, 1'b0};
        e = cyc;
        s = e + 3 + int'(baud_div_i >> 1) + 9 * int'(baud_div_i);
        if (force_pop) force_pop_at = s;
        if (time_fall) exp_fall_cyc = s;
        if (exp_push) exp_q.push_back(b);
        $display("send cycle %0d byte 0x%02h stop %0d div %0d push %0d", e, b, stop, baud_div_i, exp_push);
        for (int k = 0; k < 10; k++) begin
            rx_i = frame[k];
            repeat (bit_len) @(posedge clk_i);
            #1;
        end
        if (hold_low > 0) begin
            rx_i = 1'b0;
            idle(hold_low);
        end
        rx_i = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        auto_read = 1'b1;
        while ((exp_q.size() != 0 || !empty_o) && t < 3000) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        check("drain_in_time", int'(t < 3000), 1);
        @(negedge clk_i);
        check("empty_after_drain", int'(empty_o), 1);
        @(posedge clk_i);
        #1;
        auto_read = 1'b0;
    endtask

    initial begin
        idle(4);
        @(negedge clk_i);
        check("reset_empty", int'(empty_o), 1);
        check("reset_full", int'(full_o), 0);
        check("reset_frame_err", int'(frame_err_o), 0);
        check("reset_overrun", int'(overrun_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(5);

        // Single byte with exact empty_o fall timing
        auto_read = 1'b1;
        send_frame(8'hA5, 1'b1, 16, 1'b1, 1'b0, 1'b1, 0);
        drain();

        // Short glitch, then two back-to-back frames
        rx_i = 1'b0;
        idle(5);
        rx_i = 1'b1;
        idle(40);
        check("glitch_no_push", int'(empty_o), 1);
        check("glitch_no_err", fe_cnt, 0);
        auto_read = 1'b1;
        send_frame(8'h3C, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        idle(10);
        drain();

        // Framing error with a long low line afterwards
        send_frame(8'h55, 1'b0, 16, 1'b0, 1'b0, 1'b0, 40);
        idle(20);
        check("frame_err_count", fe_cnt, 1);
        check("frame_err_fifo_empty", int'(empty_o), 1);
        auto_read = 1'b1;
        send_frame(8'h12, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        idle(10);
        drain();

        // Fill to full, ninth byte overruns
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        end
        check("full_after_8", int'(full_o), 1);
        check("no_overrun_yet", ov_cnt, 0);
        send_frame(8'h09, 1'b1, 16, 1'b0, 1'b0, 1'b0, 0);
        idle(4);
        check("overrun_count", ov_cnt, 1);
        drain();

        // Fill again; pop on the ninth byte's push cycle keeps it
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        end
        send_frame(8'h09, 1'b1, 16, 1'b1, 1'b1, 1'b0, 0);
        idle(4);
        force_pop_at = -1;
        check("full_after_pop_push", int'(full_o), 1);
        check("overrun_still_one", ov_cnt, 1);
        drain();

        // Stall during data bit 3 with one byte already queued
        send_frame(8'h66, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        fork
            send_frame(8'h5A, 1'b1, 16, 1'b0, 1'b0, 1'b0, 0);
            begin
                idle(3 + 8 + 3 * 16 + 8);
                stall_i = 1'b1;
            end
        join
        idle(10);
        stall_i = 1'b0;
        idle(10);
        check("stall_fifo_kept", int'(empty_o), 0);
        drain();

        // Disabled by baud_div_i = 0
        baud_div_i = 16'd0;
        send_frame(8'h00, 1'b1, 16, 1'b0, 1'b0, 1'b0, 0);
        idle(20);
        check("disabled_no_push", int'(empty_o), 1);
        check("disabled_no_err", fe_cnt, 1);
        baud_div_i = 16'd16;
        idle(5);

        // Reset mid-frame with two bytes queued
        send_frame(8'h11, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h22, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        rx_i = 1'b0;
        idle(16 * 3);
        rst_i = 1'b1;
        rx_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        check("reset_midframe_empty", int'(empty_o), 1);
        @(posedge clk_i);
        #1;
        idle(20);
        auto_read = 1'b1;
        send_frame(8'h7E, 1'b1, 16, 1'b1, 1'b0, 1'b0, 0);
        idle(10);
        drain();

        check("total_frame_err", fe_cnt, 1);
        check("total_overrun", ov_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
